// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store sequencer.
// Holds FSM states, funct3/size codes and the registered request record.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    ST   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Access width in bytes; the 11 encoding always faults, so its value is don't-care.
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from up to two aligned memory words and
// sign/zero-extends them according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [63:0] both;
  logic [31:0] sel;

  always_comb begin
    both = {w1, w0} >> {off, 3'b000};
    sel  = both[31:0];
    case (funct3)
      F3_LB:   data = {{24{sel[7]}}, sel[7:0]};
      F3_LH:   data = {{16{sel[15]}}, sel[15:0]};
      F3_LBU:  data = {24'b0, sel[7:0]};
      F3_LHU:  data = {16'b0, sel[15:0]};
      default: data = sel;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: window/funct3 fault check, word-aligned reads with
// optional second word, and byte-split writes for misaligned stores.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) - 33'd1;

  lsu_state_e  state, state_nxt;
  lsu_req_t    r;
  logic        r_err;
  logic [31:0] w0, w1;
  logic [1:0]  cnt;

  logic [2:0]  in_nb;
  logic [32:0] in_last;
  logic        in_bad_f3, in_fault;
  logic        accept;

  logic [2:0]  r_nb;
  logic [1:0]  r_off;
  logic        r_aligned, r_cross;
  logic [1:0]  st_last;
  logic [31:0] ld_data;

  // Last byte computed in 33 bits so addresses near 2^32 cannot wrap into the window.
  always_comb begin
    in_nb     = nbytes(req_funct3[1:0]);
    in_last   = {1'b0, req_addr} + {30'b0, in_nb} - 33'd1;
    in_bad_f3 = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                       : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
    in_fault  = in_bad_f3 || (req_addr < BASE_ADDR) || (in_last > LIMIT);
  end

  assign accept    = req_valid && (state == IDLE);
  assign r_nb      = nbytes(r.funct3[1:0]);
  assign r_off     = r.addr[1:0];
  assign r_aligned = (r_nb == 3'd1) || (r_nb == 3'd2 && !r_off[0]) || (r_off == 2'd0);
  assign r_cross   = ({1'b0, r_off} + r_nb) > 3'd4;
  assign st_last   = r_aligned ? 2'd0 : 2'(r_nb - 3'd1);

  lsu_load_align u_align (
    .w0     (w0),
    .w1     (w1),
    .off    (r_off),
    .funct3 (r.funct3),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = in_fault ? RESP : (req_we ? ST : LD0);
      LD0:  state_nxt = r_cross ? LD1 : RESP;
      LD1:  state_nxt = RESP;
      ST:   if (cnt == st_last) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r     <= '0;
      r_err <= 1'b0;
      w0    <= '0;
      w1    <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        r     <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
        r_err <= in_fault;
        w0    <= '0;
        w1    <= '0;
        cnt   <= '0;
      end
      case (state)
        LD0:     w0  <= mem_rdata;
        LD1:     w1  <= mem_rdata;
        ST:      cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_size   = SZ_BYTE;
    case (state)
      LD0: begin
        mem_rd_en = 1'b1;
        mem_addr  = {r.addr[31:2], 2'b00};
        mem_size  = SZ_WORD;
      end
      LD1: begin
        mem_rd_en = 1'b1;
        mem_addr  = {r.addr[31:2], 2'b00} + 32'd4;
        mem_size  = SZ_WORD;
      end
      ST: begin
        mem_wr_en = 1'b1;
        if (r_aligned) begin
          mem_addr  = r.addr;
          mem_wdata = r.wdata;
          mem_size  = {1'b0, r.funct3[1:0]};
        end else begin
          mem_addr  = r.addr + {30'b0, cnt};
          mem_wdata = {24'b0, r.wdata[{cnt, 3'b000} +: 8]};
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (!r.we && !r_err) ? ld_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: byte-array memory, transaction-level
// golden model and a per-cycle monitor over the memory bus and response.
module tb_lsu_mem_ctrl;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  lsu_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  op_t  exp_ops[$];
  rsp_t exp_rsp[$];

  logic [7:0] dmem [DEPTH] = '{default: 8'h00};
  logic [7:0] gmem [DEPTH] = '{default: 8'h00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory: combinational read of 4 bytes at mem_addr, write on negedge.
  logic [31:0] rd_off, wr_off;
  logic [7:0]  ri, wi;
  always_comb begin
    rd_off    = mem_addr - BASE;
    ri        = rd_off[7:0];
    mem_rdata = '0;
    if (rd_off <= 32'(DEPTH - 4))
      mem_rdata = {dmem[ri + 8'd3], dmem[ri + 8'd2], dmem[ri + 8'd1], dmem[ri]};
  end

  always @(negedge clk) begin
    wr_off = mem_addr - BASE;
    wi     = wr_off[7:0];
    if (mem_wr_en && wr_off < 32'(DEPTH)) begin
      dmem[wi] <= mem_wdata[7:0];
      if (mem_size != 3'b000) dmem[wi + 8'd1] <= mem_wdata[15:8];
      if (mem_size == 3'b010) begin
        dmem[wi + 8'd2] <= mem_wdata[23:16];
        dmem[wi + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Per-cycle compare of bus activity and response against the model queues.
  op_t  mo;
  rsp_t mr;
  always @(negedge clk) begin
    if (mem_wr_en || mem_rd_en) begin
      chk("both_enables", {31'b0, mem_wr_en && mem_rd_en}, 32'd0);
      if (exp_ops.size() == 0) begin
        chk("unexpected_mem_op", mem_addr, 32'hxxxx_xxxx);
      end else begin
        mo = exp_ops.pop_front();
        chk("op_kind", {31'b0, mem_wr_en}, {31'b0, mo.wr});
        chk("op_addr", mem_addr, mo.addr);
        if (mo.wr) begin
          chk("op_size", {29'b0, mem_size}, {29'b0, mo.size});
          case (mo.size)
            3'b000:  chk("op_wdata", {24'b0, mem_wdata[7:0]}, mo.data & 32'hFF);
            3'b001:  chk("op_wdata", {16'b0, mem_wdata[15:0]}, mo.data & 32'hFFFF);
            default: chk("op_wdata", mem_wdata, mo.data);
          endcase
        end
      end
    end else begin
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_wdata", mem_wdata, 32'd0);
    end
    if (resp_valid) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        mr = exp_rsp[0];
        chk("resp_err", {31'b0, resp_err}, {31'b0, mr.err});
        chk("resp_rdata", resp_rdata, mr.rdata);
        if (resp_ready) void'(exp_rsp.pop_front());
      end
    end
  end

  function automatic logic [7:0] gi(input logic [31:0] a, input int i);
    logic [31:0] t;
    t = a - BASE + 32'(i);
    return t[7:0];
  endfunction

  function automatic int m_nb(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_fault(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    longint a;
    bit bad;
    a   = longint'(addr);
    bad = we ? !(f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b011, 3'b110, 3'b111});
    return bad || (a < longint'(BASE)) ||
           (a + m_nb(f3) - 1 > longint'(BASE) + DEPTH - 1);
  endfunction

  // Little-endian gather of the accessed bytes, then extension.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < m_nb(f3); i++) v = v | (32'(gmem[gi(addr, i)]) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hand_lat, input bit use_hand,
                     input logic [31:0] hand_rd, input int hold);
    int   nb, off, lat, elat;
    bit   flt, alg, got;
    op_t  o;
    rsp_t r;
    nb  = m_nb(f3);
    off = int'(addr[1:0]);
    flt = m_fault(we, f3, addr);
    alg = (off % nb) == 0;
    r.err = flt;
    r.rdata = '0;
    if (flt) begin
      elat = 1;
    end else if (we) begin
      o.wr = 1'b1;
      if (alg) begin
        o.addr = addr; o.size = {1'b0, f3[1:0]}; o.data = wdata;
        exp_ops.push_back(o);
      end else begin
        for (int i = 0; i < nb; i++) begin
          o.addr = addr + 32'(i); o.size = 3'b000; o.data = (wdata >> (8 * i)) & 32'hFF;
          exp_ops.push_back(o);
        end
      end
      for (int i = 0; i < nb; i++) gmem[gi(addr, i)] = 8'(wdata >> (8 * i));
      elat = 1 + (alg ? 1 : nb);
    end else begin
      o.wr = 1'b0; o.size = 3'b010; o.data = '0;
      o.addr = addr & ~32'd3;
      exp_ops.push_back(o);
      if (off + nb > 4) begin
        o.addr = (addr & ~32'd3) + 32'd4;
        exp_ops.push_back(o);
      end
      r.rdata = m_load(f3, addr);
      elat = (off + nb > 4) ? 3 : 2;
    end
    exp_rsp.push_back(r);

    @(posedge clk); #1;
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    chk("accept_timeout", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
      else lat++;
    end
    chk("resp_timeout", {31'b0, got}, 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    if (hand_lat != 0) chk("latency_lit", 32'(lat), 32'(hand_lat));
    if (use_hand) chk("rdata_lit", resp_rdata, hand_rd);

    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = BASE + 32'h20;
        @(negedge clk);
        chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        if (use_hand) chk("hold_rdata_lit", resp_rdata, hand_rd);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_req_ready", {31'b0, req_ready}, 32'd1);
      chk("release_resp_valid", {31'b0, resp_valid}, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_en"}, {30'b0, mem_wr_en, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_size"}, {29'b0, mem_size}, 32'd0);
  endtask

  op_t ro;
  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); reset = 1'b1;

    //  we  f3      addr                 wdata         lat hand rdata        hold
    txn(1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF, 2, 0, 32'h0,          0);
    txn(0, 3'b010, BASE + 32'h10, 32'h0,         2, 1, 32'hDEAD_BEEF,  0);
    txn(1, 3'b010, BASE + 32'h13, 32'h1122_3344, 5, 0, 32'h0,          0);
    chk("dmem_13", {24'b0, dmem[8'h13]}, 32'h44);
    chk("dmem_14", {24'b0, dmem[8'h14]}, 32'h33);
    chk("dmem_15", {24'b0, dmem[8'h15]}, 32'h22);
    chk("dmem_16", {24'b0, dmem[8'h16]}, 32'h11);
    txn(0, 3'b010, BASE + 32'h13, 32'h0,         3, 1, 32'h1122_3344,  0);
    txn(1, 3'b000, BASE + 32'h20, 32'h0000_0080, 2, 0, 32'h0,          0);
    txn(0, 3'b000, BASE + 32'h20, 32'h0,         2, 1, 32'hFFFF_FF80,  0);
    txn(0, 3'b100, BASE + 32'h20, 32'h0,         2, 1, 32'h0000_0080,  0);
    txn(1, 3'b001, BASE + 32'h23, 32'h0000_8001, 3, 0, 32'h0,          0);
    txn(0, 3'b001, BASE + 32'h23, 32'h0,         3, 1, 32'hFFFF_8001,  0);
    txn(0, 3'b101, BASE + 32'h11, 32'h0,         2, 1, 32'h0000_ADBE,  0);
    txn(1, 3'b010, BASE + 32'hFC, 32'hCAFE_F00D, 2, 0, 32'h0,          0);
    txn(0, 3'b100, BASE + 32'hFF, 32'h0,         2, 1, 32'h0000_00CA,  0);
    txn(0, 3'b010, BASE + 32'hFC, 32'h0,         2, 1, 32'hCAFE_F00D,  0);
    // Faults: window overrun, below base, 33-bit overrun, bad funct3
    txn(0, 3'b010, BASE + 32'hFE, 32'h0,         1, 1, 32'h0,          0);
    txn(0, 3'b101, BASE + 32'hFF, 32'h0,         1, 1, 32'h0,          0);
    txn(0, 3'b010, 32'h7FFF_FFFC, 32'h0,         1, 1, 32'h0,          0);
    txn(0, 3'b010, 32'hFFFF_FFFE, 32'h0,         1, 1, 32'h0,          0);
    txn(0, 3'b011, BASE + 32'h10, 32'h0,         1, 1, 32'h0,          0);
    txn(1, 3'b100, BASE + 32'h10, 32'h1234_5678, 1, 1, 32'h0,          0);
    // Backpressure on a load response
    txn(0, 3'b010, BASE + 32'h10, 32'h0,         2, 1, 32'h44AD_BEEF,  3);

    // Reset after two of four byte writes of a misaligned store
    ro.wr = 1'b1; ro.size = 3'b000;
    ro.addr = BASE + 32'h31; ro.data = 32'hDD; exp_ops.push_back(ro);
    ro.addr = BASE + 32'h32; ro.data = 32'hCC; exp_ops.push_back(ro);
    gmem[8'h31] = 8'hDD;
    gmem[8'h32] = 8'hCC;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = BASE + 32'h31; req_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("mid_reset_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk); reset = 1'b1;
    chk("partial_31", {24'b0, dmem[8'h31]}, 32'hDD);
    chk("partial_32", {24'b0, dmem[8'h32]}, 32'hCC);
    chk("partial_33", {24'b0, dmem[8'h33]}, 32'h00);
    chk("partial_34", {24'b0, dmem[8'h34]}, 32'h00);
    txn(0, 3'b010, BASE + 32'h30, 32'h0,         2, 1, 32'h00CC_DD00,  0);

    repeat (3) @(negedge clk);
    chk("ops_left", 32'(exp_ops.size()), 32'd0);
    chk("resps_left", 32'(exp_rsp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's execute stage and the byte-addressed data memory. It accepts one load/store request at a time, checks the address window and funct3, and drives the data memory's wr_en/rd_en/addr/wdata/size. Misaligned accesses are split into multiple memory cycles. It returns a sign- or zero-extended load result, or an access-fault flag, over a valid/ready response channel.

Parameters:
BASE_ADDR, 32'h8000_0000, first byte address of the data memory window
DEPTH, 256, window size in bytes; must be a multiple of 4

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_err  out  1  access fault
mem_wr_en  out  1  data memory write enable (memory writes on negedge)
mem_rd_en  out  1  data memory read enable
mem_addr  out  32  data memory byte address
mem_wdata  out  32  data memory write data
mem_size  out  3  000 byte, 001 half, 010 word
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE. req_ready=1; resp_valid=0; resp_err=0. resp_rdata, mem_* outputs and all internal registers are 0.
- Request handshake: a request is taken when req_valid&&req_ready. req_ready=1 only in IDLE. Request fields are registered on acceptance.
- nbytes: 1 for funct3 x00, 2 for x01, 4 for x10. off = addr[1:0].
- Fault conditions:
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010};
  - addr < BASE_ADDR;
  - addr+nbytes-1 > BASE_ADDR+DEPTH-1, computed in 33 bits so there is no wrap.
- Fault handling: IDLE -> RESP with resp_err=1. No mem_rd_en or mem_wr_en pulse is issued.
- States: IDLE, LD0, LD1, ST, RESP.
- Aligned store (off % nbytes == 0): one ST cycle.
  - mem_wr_en=1, mem_addr=addr, mem_wdata=wdata, mem_size from funct3[1:0].
- Misaligned store: ST lasts nbytes cycles.
  - Cycle i: mem_size=000, mem_addr=addr+i, mem_wdata[7:0]=wdata[8i+7:8i]. A byte counter is used.
- Loads always read word-aligned.
  - LD0: mem_rd_en=1, mem_addr=addr&~3; mem_rdata is captured as w0.
  - If off+nbytes > 4: go to LD1, with mem_addr=(addr&~3)+4; capture w1. Otherwise go to RESP.
- Load result: sel = ({w1,w0} >> 8*off)[31:0], then extend.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: sel unchanged.
- RESP: resp_valid=1 and resp_rdata/resp_err held stable until resp_ready=1; then return to IDLE. There is no direct RESP->IDLE->accept bypass, so the next acceptance is no earlier than the following cycle.
- Latency, with acceptance at cycle N (resp_valid first high at):
  - fault: N+1
  - aligned or non-crossing load: N+2
  - word-crossing load: N+3
  - store: N+1+k, where k = number of write cycles
- Outside the write and read cycles, mem_wr_en=0 and mem_rd_en=0.
- mem_addr and mem_wdata are 0 whenever neither memory enable is active.
- Reset mid-operation: outputs drop to reset values immediately (asynchronous). Remaining split byte writes are abandoned; a partial misaligned store is accepted behaviour.
- req_valid in a non-IDLE state is ignored; the requester must hold it.

Decomposition:
- Package lsu_pkg:
  - lsu_state_e enum (IDLE, LD0, LD1, ST, RESP);
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Sub-module lsu_load_align: purely combinational. Inputs w0, w1, off, funct3; output is the extended 32-bit data.
- FSM, byte counter and fault check stay in lsu_mem_ctrl.

Test Plan:
- SW 0x8000_0010 <- 0xDEADBEEF, then LW 0x8000_0010 -> one mem_wr_en cycle (size 010). The load gives resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at N+2.
- SW 0x8000_0013 <- 0x11223344 -> four byte writes: 0x13=44, 0x14=33, 0x15=22, 0x16=11; resp at N+5. Then LW 0x8000_0013 -> reads at 0x10 and 0x14, resp_rdata=0x11223344 at N+3.
- Byte 0x80 stored at 0x8000_0020 -> LB returns 0xFFFFFF80, LBU returns 0x00000080. Then SH 0x8000_0023 <- 0x8001 followed by LH 0x8000_0023 -> 0xFFFF8001 (two reads).
- LW 0x8000_00FE, LW 0x7FFF_FFFC, and load funct3=011 -> each gives resp_err=1, resp_rdata=0, resp at N+1, no memory enable pulse.
- resp_ready held 0 for 3 cycles after a load -> resp_valid/resp_rdata stable, req_ready=0, a concurrent req_valid is not accepted. Release -> IDLE on the next cycle.
- Drive reset=0 after 2 byte writes of a misaligned SW -> all outputs reset immediately; only 2 bytes are modified. After release, req_ready=1 and a new LW completes normally.
